// File: rtl/prog_frediv_pkg.sv
// Shared defaults and helpers for the programmable multi-channel frequency divider.
package prog_frediv_pkg;

  localparam int N_DEF           = 26;
  localparam int DEFAULT_DIV_DEF = 50000000;

  // Width of the channel-select field; a single channel still gets one bit.
  function automatic int chsel_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/frediv_chan.sv
// One divider channel: active/shadow divisor, pending flag, period counter and
// registered clk_out/tick. Divisor changes take effect only on a period boundary.
module frediv_chan
  import prog_frediv_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         wr_i,
  input  logic [N-1:0] div_i,
  output logic         pending_o,
  output logic         clk_out_o,
  output logic         tick_o
);

  localparam logic [N-1:0] DIV_RST = N'(DEFAULT_DIV);
  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] TWO     = N'(2);

  logic [N-1:0] act_q, act_d;
  logic [N-1:0] shd_q, shd_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         running, wrap, apply;

  always_comb begin
    running = en_i && (act_q >= TWO);
    wrap    = running && (cnt_q == act_q - ONE);
    // A running channel only swaps divisors at the wrap so the period never glitches.
    apply   = pend_q && (wrap || !running);

    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;

    if (running) begin
      cnt_d  = wrap ? '0 : cnt_q + ONE;
      clk_d  = (cnt_q < (act_q >> 1));
      tick_d = wrap;
    end else begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end

    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    // A write on the apply edge lands in the shadow and stays pending for the next one.
    if (wr_i) begin
      shd_d  = div_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      act_q  <= DIV_RST;
      shd_q  <= DIV_RST;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/prog_frediv.sv
// Programmable NCH-channel frequency divider; the top only decodes divisor writes
// into per-channel strobes.
module prog_frediv
  import prog_frediv_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int N           = N_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CW          = chsel_w(NCH)
) (
  input  logic           CLK_50M,
  input  logic           nCR,
  input  logic [NCH-1:0] en,
  input  logic           cfg_wr,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [N-1:0]   cfg_div,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_wr && (cfg_ch == CW'(i));

    frediv_chan #(
      .N           (N),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i     (CLK_50M),
      .rst_n_i   (nCR),
      .en_i      (en[i]),
      .wr_i      (wr),
      .div_i     (cfg_div),
      .pending_o (pending[i]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_frediv.sv
// Scoreboard bench for prog_frediv: three channels, 8-bit divisors, reset divisor 10.
module tb_prog_frediv;

  localparam int NCH = 3;
  localparam int N   = 8;
  localparam int DD  = 10;

  logic           CLK_50M = 1'b0;
  logic           nCR     = 1'b0;
  logic [NCH-1:0] en      = '0;
  logic           cfg_wr  = 1'b0;
  logic [1:0]     cfg_ch  = '0;
  logic [N-1:0]   cfg_div = '0;
  logic [NCH-1:0] pending, clk_out, tick;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t sb[$];

  always #5 CLK_50M = ~CLK_50M;

  prog_frediv #(.NCH(NCH), .N(N), .DEFAULT_DIV(DD)) dut (
    .CLK_50M (CLK_50M),
    .nCR     (nCR),
    .en      (en),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .pending (pending),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // Ideal waveform of a divider j cycles into its run with divisor d.
  function automatic logic pc(input int j, input int d);
    return (j % d) < (d / 2);
  endfunction

  function automatic logic pt(input int j, input int d);
    return (j % d) == (d - 1);
  endfunction

  task automatic step();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic drive_wr(input int ch, input int d);
    cfg_wr  = 1'b1;
    cfg_ch  = ch[1:0];
    cfg_div = d[N-1:0];
  endtask

  task automatic do_reset();
    nCR    = 1'b0;
    en     = '0;
    cfg_wr = 1'b0;
    step();
    nCR = 1'b1;
  endtask

  task automatic setup_ch0_d4();
    do_reset();
    drive_wr(0, 4);
    step();
    cfg_wr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    exp_t e;
    nCR = 1'b0;
    en  = '1;
    drive_wr(0, 3);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{c: '0, t: '0, p: '0});
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL reset clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL reset tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL reset pending k=%0d got %b want %b", k, pending, e.p); end
    end
    cfg_wr = 1'b0;
    en     = '0;
    nCR    = 1'b1;
  endtask

  task automatic test_div4();
    exp_t e;
    do_reset();
    drive_wr(0, 4);
    sb.push_back('{c: '0, t: '0, p: 3'b001});
    step();
    e = sb.pop_front();
    checks++; if (pending !== e.p) begin errors++; $display("FAIL div4 pending after write got %b want %b", pending, e.p); end
    cfg_wr = 1'b0;
    sb.push_back('{c: '0, t: '0, p: '0});
    step();
    e = sb.pop_front();
    checks++; if (pending !== e.p) begin errors++; $display("FAIL div4 pending idle apply got %b want %b", pending, e.p); end
    en = 3'b001;
    for (int k = 0; k < 12; k++) begin
      e.c = {2'b00, pc(k, 4)};
      e.t = {2'b00, pt(k, 4)};
      e.p = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL div4 clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL div4 tick k=%0d got %b want %b", k, tick, e.t); end
    end
  endtask

  task automatic test_two_ch();
    exp_t e;
    do_reset();
    drive_wr(0, 4);
    step();
    drive_wr(1, 5);
    step();
    cfg_wr = 1'b0;
    step();
    en = 3'b011;
    for (int k = 0; k < 20; k++) begin
      e.c = {1'b0, pc(k, 5), pc(k, 4)};
      e.t = {1'b0, pt(k, 5), pt(k, 4)};
      e.p = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL two_ch clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL two_ch tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL two_ch pending k=%0d got %b want %b", k, pending, e.p); end
    end
  endtask

  task automatic test_midperiod();
    exp_t e;
    setup_ch0_d4();
    en = 3'b001;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) drive_wr(0, 6);
      else        cfg_wr = 1'b0;
      if (k < 4) begin
        e.c = {2'b00, pc(k, 4)};
        e.t = {2'b00, pt(k, 4)};
        e.p = {2'b00, (k == 1 || k == 2)};
      end else begin
        e.c = {2'b00, pc(k - 4, 6)};
        e.t = {2'b00, pt(k - 4, 6)};
        e.p = '0;
      end
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL midperiod clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL midperiod tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL midperiod pending k=%0d got %b want %b", k, pending, e.p); end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_wrap_coincide();
    exp_t e;
    setup_ch0_d4();
    en = 3'b001;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) drive_wr(0, 8);
      else        cfg_wr = 1'b0;
      if (k < 8) begin
        e.c = {2'b00, pc(k, 4)};
        e.t = {2'b00, pt(k, 4)};
        e.p = {2'b00, (k >= 3 && k <= 6)};
      end else begin
        e.c = {2'b00, pc(k - 8, 8)};
        e.t = {2'b00, pt(k - 8, 8)};
        e.p = '0;
      end
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL wrap_coincide clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL wrap_coincide tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL wrap_coincide pending k=%0d got %b want %b", k, pending, e.p); end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_idle_div();
    exp_t e;
    setup_ch0_d4();
    en = 3'b001;
    for (int k = 0; k < 20; k++) begin
      if      (k == 0)  drive_wr(0, 1);
      else if (k == 5)  drive_wr(0, 0);
      else if (k == 10) drive_wr(0, 4);
      else              cfg_wr = 1'b0;
      if (k < 4) begin
        e.c = {2'b00, pc(k, 4)};
        e.t = {2'b00, pt(k, 4)};
        e.p = {2'b00, (k <= 2)};
      end else if (k < 12) begin
        e.c = '0;
        e.t = '0;
        e.p = {2'b00, (k == 5 || k == 10)};
      end else begin
        e.c = {2'b00, pc(k - 12, 4)};
        e.t = {2'b00, pt(k - 12, 4)};
        e.p = '0;
      end
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL idle_div clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL idle_div tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL idle_div pending k=%0d got %b want %b", k, pending, e.p); end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    setup_ch0_d4();
    en = 3'b001;
    for (int k = 0; k < 18; k++) begin
      if      (k == 0) drive_wr(0, 6);
      else if (k == 1) drive_wr(0, 7);
      else if (k == 2) drive_wr(3, 2);
      else             cfg_wr = 1'b0;
      if (k < 4) begin
        e.c = {2'b00, pc(k, 4)};
        e.t = {2'b00, pt(k, 4)};
        e.p = {2'b00, (k <= 2)};
      end else begin
        e.c = {2'b00, pc(k - 4, 7)};
        e.t = {2'b00, pt(k - 4, 7)};
        e.p = '0;
      end
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL back_to_back clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL back_to_back tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL back_to_back pending k=%0d got %b want %b", k, pending, e.p); end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    setup_ch0_d4();
    en = 3'b011;
    for (int k = 0; k < 30; k++) begin
      nCR    = (k != 5);
      cfg_wr = 1'b0;
      if (k == 4) drive_wr(0, 6);
      if (k == 5) drive_wr(1, 3);
      if (k == 12) begin
        #2 nCR = 1'b0;
        #2 nCR = 1'b1;
      end
      if (k < 5) begin
        e.c = {1'b0, pc(k, DD), pc(k, 4)};
        e.t = {1'b0, pt(k, DD), pt(k, 4)};
        e.p = {2'b00, (k == 4)};
      end else if (k == 5) begin
        e.c = '0;
        e.t = '0;
        e.p = '0;
      end else begin
        e.c = {1'b0, pc(k - 6, DD), pc(k - 6, DD)};
        e.t = {1'b0, pt(k - 6, DD), pt(k - 6, DD)};
        e.p = '0;
      end
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (clk_out !== e.c) begin errors++; $display("FAIL reset_mid clk_out k=%0d got %b want %b", k, clk_out, e.c); end
      checks++; if (tick    !== e.t) begin errors++; $display("FAIL reset_mid tick k=%0d got %b want %b", k, tick, e.t); end
      checks++; if (pending !== e.p) begin errors++; $display("FAIL reset_mid pending k=%0d got %b want %b", k, pending, e.p); end
    end
    nCR    = 1'b1;
    cfg_wr = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_div4();
    test_two_ch();
    test_midperiod();
    test_wrap_coincide();
    test_idle_div();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
